// File: rtl/lsu_queue_if.sv
// Core/memory handshake bundle for the load/store queue.
// slave is the queue's view; master is the core-plus-memory environment.
interface lsu_queue_if #(
    parameter int unsigned data_width_p = 32,
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned depth_p      = 4
);
    localparam int unsigned be_width_lp  = data_width_p / 8;
    localparam int unsigned cnt_width_lp = $clog2(depth_p + 1);

    // Core request side
    logic                    core_valid_i;
    logic                    core_wen_i;
    logic [1:0]              core_size_i;
    logic                    core_signed_i;
    logic [addr_width_p-1:0] core_addr_i;
    logic [data_width_p-1:0] core_wdata_i;
    logic                    core_ready_o;

    // Core response side
    logic                    core_resp_valid_o;
    logic                    core_resp_wen_o;
    logic [data_width_p-1:0] core_rdata_o;
    logic                    core_resp_yumi_i;

    // Memory request side
    logic                    mem_valid_o;
    logic                    mem_wen_o;
    logic [addr_width_p-1:0] mem_addr_o;
    logic [be_width_lp-1:0]  mem_be_o;
    logic [data_width_p-1:0] mem_wdata_o;
    logic                    mem_yumi_i;

    // Memory response side
    logic                    mem_resp_valid_i;
    logic [data_width_p-1:0] mem_rdata_i;
    logic                    mem_resp_yumi_o;

    // Status
    logic [cnt_width_lp-1:0] pending_o;
    logic                    exception_o;

    modport slave (
        input  core_valid_i, core_wen_i, core_size_i, core_signed_i, core_addr_i,
        input  core_wdata_i, core_resp_yumi_i, mem_yumi_i, mem_resp_valid_i, mem_rdata_i,
        output core_ready_o, core_resp_valid_o, core_resp_wen_o, core_rdata_o,
        output mem_valid_o, mem_wen_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_resp_yumi_o, pending_o, exception_o
    );

    modport master (
        output core_valid_i, core_wen_i, core_size_i, core_signed_i, core_addr_i,
        output core_wdata_i, core_resp_yumi_i, mem_yumi_i, mem_resp_valid_i, mem_rdata_i,
        input  core_ready_o, core_resp_valid_o, core_resp_wen_o, core_rdata_o,
        input  mem_valid_o, mem_wen_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_resp_yumi_o, pending_o, exception_o
    );
endinterface

// File: rtl/lsu_queue.sv
// In-order load/store queue: request FIFO -> memory -> in-flight FIFO -> response register.
// Byte enables and lane-replicated store data are formed at acceptance so nothing on
// the memory request side depends combinationally on the core inputs.
module lsu_queue #(
    parameter int unsigned data_width_p = 32,
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned depth_p      = 4
) (
    input logic          clk,
    input logic          n_reset,
    lsu_queue_if.slave   bus
);
    localparam int unsigned nb_lp    = data_width_p / 8;
    localparam int unsigned off_w_lp = $clog2(nb_lp);
    localparam int unsigned idx_w_lp = $clog2(depth_p);
    localparam int unsigned ptr_w_lp = idx_w_lp + 1;
    localparam int unsigned cnt_w_lp = $clog2(depth_p + 1);
    localparam logic [cnt_w_lp-1:0] depth_cnt_lp = cnt_w_lp'(depth_p);

    // Request FIFO storage
    logic                    req_wen_q    [depth_p];
    logic [addr_width_p-1:0] req_addr_q   [depth_p];
    logic [nb_lp-1:0]        req_be_q     [depth_p];
    logic [data_width_p-1:0] req_wdata_q  [depth_p];
    logic [1:0]              req_size_q   [depth_p];
    logic                    req_signed_q [depth_p];
    logic [off_w_lp-1:0]     req_off_q    [depth_p];
    logic [ptr_w_lp-1:0]     req_wr_q, req_rd_q;

    // In-flight FIFO storage (metadata only)
    logic                    fl_wen_q    [depth_p];
    logic [1:0]              fl_size_q   [depth_p];
    logic                    fl_signed_q [depth_p];
    logic [off_w_lp-1:0]     fl_off_q    [depth_p];
    logic [ptr_w_lp-1:0]     fl_wr_q, fl_rd_q;

    logic                    resp_valid_q, resp_wen_q;
    logic [data_width_p-1:0] resp_rdata_q;
    logic [cnt_w_lp-1:0]     pending_q, pending_d;
    logic                    exception_q;

    logic                    core_ready, accept, legal, push_req;
    logic                    req_empty, fl_empty, mem_pop, resp_take, resp_drain;
    logic [off_w_lp-1:0]     in_off;
    logic [nb_lp-1:0]        lane_mask, in_be;
    logic [data_width_p-1:0] in_wdata;
    logic [idx_w_lp-1:0]     req_head, fl_head;
    logic [data_width_p-1:0] shifted, ext_mask, load_data, resp_next;
    logic                    sign_bit;

    // Ready is masked by reset so every output reads 0 while reset is held.
    assign core_ready = n_reset && (pending_q < depth_cnt_lp);
    assign accept     = bus.core_valid_i && core_ready;
    assign push_req   = accept && legal;
    assign in_off     = bus.core_addr_i[off_w_lp-1:0];

    assign req_empty  = (req_wr_q == req_rd_q);
    assign fl_empty   = (fl_wr_q == fl_rd_q);
    assign req_head   = req_rd_q[idx_w_lp-1:0];
    assign fl_head    = fl_rd_q[idx_w_lp-1:0];
    assign mem_pop    = !req_empty && bus.mem_yumi_i;
    // Responses with nothing in flight are not ours and are left unconsumed.
    assign resp_take  = bus.mem_resp_valid_i && !fl_empty && (!resp_valid_q || bus.core_resp_yumi_i);
    assign resp_drain = resp_valid_q && bus.core_resp_yumi_i;

    // Alignment/size legality, byte enables and lane-replicated store data of the incoming request
    always_comb begin
        legal     = 1'b0;
        lane_mask = '0;
        in_wdata  = '0;
        unique case (bus.core_size_i)
            2'd0: begin
                legal     = 1'b1;
                lane_mask = nb_lp'(1);
                in_wdata  = {nb_lp{bus.core_wdata_i[7:0]}};
            end
            2'd1: begin
                legal     = !bus.core_addr_i[0];
                lane_mask = nb_lp'(3);
                in_wdata  = {(nb_lp / 2){bus.core_wdata_i[15:0]}};
            end
            2'd2: begin
                legal     = (bus.core_addr_i[1:0] == 2'b00);
                lane_mask = nb_lp'(15);
                in_wdata  = {(data_width_p / 32){bus.core_wdata_i[31:0]}};
            end
            2'd3: begin
                legal     = (data_width_p == 64) && (bus.core_addr_i[2:0] == 3'b000);
                lane_mask = '1;
                in_wdata  = bus.core_wdata_i;
            end
        endcase
        in_be = lane_mask << in_off;
    end

    // Extract, mask and extend the load result for the in-flight head
    always_comb begin
        shifted  = bus.mem_rdata_i >> {fl_off_q[fl_head], 3'b000};
        ext_mask = '1;
        sign_bit = 1'b0;
        unique case (fl_size_q[fl_head])
            2'd0: begin
                ext_mask = data_width_p'(8'hFF);
                sign_bit = shifted[7];
            end
            2'd1: begin
                ext_mask = data_width_p'(16'hFFFF);
                sign_bit = shifted[15];
            end
            2'd2: begin
                ext_mask = data_width_p'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            2'd3: begin
                ext_mask = '1;
                sign_bit = shifted[data_width_p-1];
            end
        endcase
        load_data = (shifted & ext_mask)
                  | ({data_width_p{fl_signed_q[fl_head] & sign_bit}} & ~ext_mask);
        resp_next = fl_wen_q[fl_head] ? '0 : load_data;
    end

    // Occupancy: legal accept adds, response hand-off removes
    always_comb begin
        pending_d = pending_q;
        if (push_req && !resp_drain) begin
            pending_d = pending_q + cnt_w_lp'(1);
        end else if (!push_req && resp_drain) begin
            pending_d = pending_q - cnt_w_lp'(1);
        end
    end

    // FIFO payload writes; entries are only read once their pointer says they are valid
    always_ff @(posedge clk) begin
        if (push_req) begin
            req_wen_q[req_wr_q[idx_w_lp-1:0]]    <= bus.core_wen_i;
            req_addr_q[req_wr_q[idx_w_lp-1:0]]   <= {bus.core_addr_i[addr_width_p-1:off_w_lp],
                                                     {off_w_lp{1'b0}}};
            req_be_q[req_wr_q[idx_w_lp-1:0]]     <= in_be;
            req_wdata_q[req_wr_q[idx_w_lp-1:0]]  <= in_wdata;
            req_size_q[req_wr_q[idx_w_lp-1:0]]   <= bus.core_size_i;
            req_signed_q[req_wr_q[idx_w_lp-1:0]] <= bus.core_signed_i;
            req_off_q[req_wr_q[idx_w_lp-1:0]]    <= in_off;
        end
        if (mem_pop) begin
            fl_wen_q[fl_wr_q[idx_w_lp-1:0]]    <= req_wen_q[req_head];
            fl_size_q[fl_wr_q[idx_w_lp-1:0]]   <= req_size_q[req_head];
            fl_signed_q[fl_wr_q[idx_w_lp-1:0]] <= req_signed_q[req_head];
            fl_off_q[fl_wr_q[idx_w_lp-1:0]]    <= req_off_q[req_head];
        end
    end

    // Pointers, response register, occupancy and sticky exception
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            req_wr_q     <= '0;
            req_rd_q     <= '0;
            fl_wr_q      <= '0;
            fl_rd_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_wen_q   <= 1'b0;
            resp_rdata_q <= '0;
            pending_q    <= '0;
            exception_q  <= 1'b0;
        end else begin
            if (push_req)  req_wr_q <= req_wr_q + ptr_w_lp'(1);
            if (mem_pop)   req_rd_q <= req_rd_q + ptr_w_lp'(1);
            if (mem_pop)   fl_wr_q  <= fl_wr_q + ptr_w_lp'(1);
            if (resp_take) fl_rd_q  <= fl_rd_q + ptr_w_lp'(1);
            if (resp_take) begin
                resp_valid_q <= 1'b1;
                resp_wen_q   <= fl_wen_q[fl_head];
                resp_rdata_q <= resp_next;
            end else if (resp_drain) begin
                resp_valid_q <= 1'b0;
            end
            pending_q <= pending_d;
            if (accept && !legal) exception_q <= 1'b1;
        end
    end

    assign bus.core_ready_o      = core_ready;
    assign bus.core_resp_valid_o = resp_valid_q;
    assign bus.core_resp_wen_o   = resp_wen_q;
    assign bus.core_rdata_o      = resp_rdata_q;
    assign bus.mem_valid_o       = !req_empty;
    assign bus.mem_wen_o         = !req_empty && req_wen_q[req_head];
    assign bus.mem_addr_o        = req_empty ? '0 : req_addr_q[req_head];
    assign bus.mem_be_o          = req_empty ? '0 : req_be_q[req_head];
    assign bus.mem_wdata_o       = req_empty ? '0 : req_wdata_q[req_head];
    assign bus.mem_resp_yumi_o   = resp_take;
    assign bus.pending_o         = pending_q;
    assign bus.exception_o       = exception_q;
endmodule

// File: tb/tb_lsu_queue.sv
// Bench for lsu_queue: scenario tasks drive the core side, a behavioural memory answers
// in order, and a scoreboard checks every response handed to the core.
module tb_lsu_queue;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic        wen;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    lsu_queue_if #(.data_width_p(DW), .addr_width_p(AW), .depth_p(DEPTH)) ifc ();

    lsu_queue #(.data_width_p(DW), .addr_width_p(AW), .depth_p(DEPTH)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (ifc)
    );

    int checks = 0;
    int errors = 0;
    resp_t       sb[$];
    logic [31:0] mem_data_q[$];
    logic [31:0] resp_q[$];
    logic        mem_yumi_en = 1'b1;

    // Memory model: accepts when enabled, answers each accepted request in order.
    initial begin
        logic acc_req, acc_resp;
        ifc.mem_yumi_i       = 1'b0;
        ifc.mem_resp_valid_i = 1'b0;
        ifc.mem_rdata_i      = '0;
        forever begin
            @(negedge clk);
            acc_req  = ifc.mem_valid_o && ifc.mem_yumi_i;
            acc_resp = ifc.mem_resp_valid_i && ifc.mem_resp_yumi_o;
            @(posedge clk);
            #2;
            if (acc_req) begin
                if (mem_data_q.size() > 0) begin
                    resp_q.push_back(mem_data_q.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected_request: got addr %h, required no request",
                             ifc.mem_addr_o);
                end
            end
            if (acc_resp && resp_q.size() > 0) void'(resp_q.pop_front());
            if (!n_reset) begin
                mem_data_q.delete();
                resp_q.delete();
            end
            ifc.mem_yumi_i       = mem_yumi_en;
            ifc.mem_resp_valid_i = (resp_q.size() > 0);
            ifc.mem_rdata_i      = (resp_q.size() > 0) ? resp_q[0] : 32'h0;
        end
    end

    // Scoreboard: compare each response consumed by the core against the expected queue.
    initial begin
        resp_t exp;
        forever begin
            @(negedge clk);
            if (n_reset && ifc.core_resp_valid_o && ifc.core_resp_yumi_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got wen=%b rdata=%h, required none",
                             ifc.core_resp_wen_o, ifc.core_rdata_o);
                end else begin
                    exp = sb.pop_front();
                    if ({ifc.core_resp_wen_o, ifc.core_rdata_o} !== exp) begin
                        errors++;
                        $display("FAIL resp_data: got wen=%b rdata=%h, required wen=%b rdata=%h",
                                 ifc.core_resp_wen_o, ifc.core_rdata_o, exp.wen, exp.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one request and hold it until accepted; returns cycles spent waiting.
    task automatic issue(input logic wen, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic legal,
                         input logic [31:0] raw, input logic [31:0] exp, output int waited);
        ifc.core_valid_i  = 1'b1;
        ifc.core_wen_i    = wen;
        ifc.core_size_i   = size;
        ifc.core_signed_i = sgn;
        ifc.core_addr_i   = addr;
        ifc.core_wdata_i  = wdata;
        waited = 0;
        while (!ifc.core_ready_o && waited < 50) begin
            step(1);
            waited++;
        end
        if (!ifc.core_ready_o) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got ready=0 at addr %h, required ready=1", addr);
            ifc.core_valid_i = 1'b0;
            return;
        end
        if (legal) begin
            mem_data_q.push_back(raw);
            sb.push_back({wen, exp});
        end
        step(1);
        ifc.core_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while ((sb.size() != 0 || ifc.pending_o != 0) && cyc < 200) begin
            step(1);
            cyc++;
        end
        checks++;
        if (sb.size() != 0 || ifc.pending_o != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d expected responses left, pending=%0d, required 0/0",
                     name, sb.size(), ifc.pending_o);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [8:0] obs;
        obs = {ifc.core_ready_o, ifc.mem_valid_o, ifc.mem_wen_o, ifc.core_resp_valid_o,
               ifc.core_resp_wen_o, ifc.mem_resp_yumi_o, ifc.exception_o, 2'b00};
        checks++;
        if (obs !== 9'h0) begin
            errors++;
            $display("FAIL %s_flags: got %b, required 000000000", name, obs);
        end
        checks++;
        if (ifc.pending_o !== 3'd0 || ifc.core_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL %s_pending_rdata: got pending=%0d rdata=%h, required 0 and 0",
                     name, ifc.pending_o, ifc.core_rdata_o);
        end
    endtask

    task automatic test_reset();
        step(2);
        check_all_zero("reset");
        n_reset = 1'b1;
        step(1);
        checks++;
        if (ifc.core_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", ifc.core_ready_o);
        end
    endtask

    task automatic test_word_load();
        int w;
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, w);
        checks++;
        if ({ifc.mem_valid_o, ifc.mem_wen_o, ifc.mem_be_o, ifc.mem_addr_o} !==
            {1'b1, 1'b0, 4'hF, 32'h100}) begin
            errors++;
            $display("FAIL word_load_req: got v=%b w=%b be=%h addr=%h, required 1 0 f 00000100",
                     ifc.mem_valid_o, ifc.mem_wen_o, ifc.mem_be_o, ifc.mem_addr_o);
        end
        wait_drain("word_load");
    endtask

    task automatic test_signed_byte();
        int w;
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b1, 32'h80123456, 32'hFFFFFF80, w);
        checks++;
        if (ifc.mem_be_o !== 4'h8 || ifc.mem_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL byte_load_be: got be=%h addr=%h, required 8 00000100",
                     ifc.mem_be_o, ifc.mem_addr_o);
        end
        wait_drain("signed_byte");
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b1, 32'h80123456, 32'h00000080, w);
        wait_drain("unsigned_byte");
    endtask

    task automatic test_half_store();
        int w;
        issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 1'b1, 32'h5555AAAA, 32'h0, w);
        checks++;
        if ({ifc.mem_valid_o, ifc.mem_wen_o, ifc.mem_be_o} !== {1'b1, 1'b1, 4'hC}) begin
            errors++;
            $display("FAIL half_store_ctl: got v=%b w=%b be=%h, required 1 1 c",
                     ifc.mem_valid_o, ifc.mem_wen_o, ifc.mem_be_o);
        end
        checks++;
        if (ifc.mem_wdata_o !== 32'hABCDABCD || ifc.mem_addr_o !== 32'h200) begin
            errors++;
            $display("FAIL half_store_data: got wdata=%h addr=%h, required abcdabcd 00000200",
                     ifc.mem_wdata_o, ifc.mem_addr_o);
        end
        wait_drain("half_store");
    endtask

    task automatic test_backpressure();
        int w;
        mem_yumi_en          = 1'b0;
        ifc.core_resp_yumi_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 2'd2, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 1'b1,
                  32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(i), w);
        end
        ifc.core_valid_i = 1'b1;
        ifc.core_addr_i  = 32'h310;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ifc.core_ready_o !== 1'b0 || ifc.pending_o !== 3'd4) begin
                errors++;
                $display("FAIL bp_full: got ready=%b pending=%0d, required 0 and 4",
                         ifc.core_ready_o, ifc.pending_o);
            end
            step(1);
        end
        ifc.core_valid_i = 1'b0;
        mem_yumi_en      = 1'b1;
        step(8);
        @(negedge clk);
        checks++;
        if ({ifc.core_resp_valid_o, ifc.mem_resp_valid_i, ifc.mem_resp_yumi_o} !== 3'b110) begin
            errors++;
            $display("FAIL bp_resp_hold: got resp_valid=%b mem_resp_valid=%b yumi=%b, required 1 1 0",
                     ifc.core_resp_valid_o, ifc.mem_resp_valid_i, ifc.mem_resp_yumi_o);
        end
        @(posedge clk);
        #1;
        ifc.core_resp_yumi_i = 1'b1;
        checks++;
        if (ifc.core_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain_ready: got %b, required 0 until next cycle",
                     ifc.core_ready_o);
        end
        issue(1'b0, 2'd2, 1'b0, 32'h310, 32'h0, 1'b1, 32'h2000_0005, 32'h2000_0005, w);
        issue(1'b0, 2'd2, 1'b0, 32'h314, 32'h0, 1'b1, 32'h2000_0006, 32'h2000_0006, w);
        wait_drain("backpressure");
    endtask

    task automatic test_misaligned();
        int w;
        checks++;
        if (ifc.exception_o !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_pre: got exception=%b, required 0", ifc.exception_o);
        end
        issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1'b0, 32'h0, 32'h0, w);
        checks++;
        if ({ifc.exception_o, ifc.mem_valid_o, ifc.pending_o} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL misaligned: got exc=%b mem_valid=%b pending=%0d, required 1 0 0",
                     ifc.exception_o, ifc.mem_valid_o, ifc.pending_o);
        end
        issue(1'b0, 2'd0, 1'b0, 32'h105, 32'h0, 1'b1, 32'h0000AB00, 32'h000000AB, w);
        wait_drain("after_misaligned");
        checks++;
        if (ifc.exception_o !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_sticky: got exception=%b, required 1", ifc.exception_o);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int total = 0;
        issue(1'b0, 2'd1, 1'b1, 32'h402, 32'h0, 1'b1, 32'h80010000, 32'hFFFF8001, w);
        total += w;
        issue(1'b0, 2'd0, 1'b0, 32'h401, 32'h0, 1'b1, 32'h0000AB00, 32'h000000AB, w);
        total += w;
        issue(1'b1, 2'd2, 1'b0, 32'h404, 32'h12345678, 1'b1, 32'hFFFFFFFF, 32'h0, w);
        total += w;
        issue(1'b0, 2'd1, 1'b0, 32'h406, 32'h0, 1'b1, 32'hFEDC0000, 32'h0000FEDC, w);
        total += w;
        checks++;
        if (total != 0) begin
            errors++;
            $display("FAIL back_to_back_stall: got %0d stall cycles, required 0", total);
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        int w;
        mem_yumi_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 2'd2, 1'b0, 32'h600 + 32'(4 * i), 32'h0, 1'b1, 32'h0, 32'h0, w);
        end
        checks++;
        if (ifc.pending_o !== 3'd3 || ifc.mem_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got pending=%0d mem_valid=%b, required 3 1",
                     ifc.pending_o, ifc.mem_valid_o);
        end
        n_reset = 1'b0;
        #1;
        check_all_zero("reset_mid");
        sb.delete();
        mem_data_q.delete();
        step(2);
        n_reset     = 1'b1;
        mem_yumi_en = 1'b1;
        step(1);
        issue(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, w);
        wait_drain("after_reset");
        checks++;
        if (ifc.exception_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_exception: got %b, required 0", ifc.exception_o);
        end
    endtask

    initial begin
        ifc.core_valid_i     = 1'b0;
        ifc.core_wen_i       = 1'b0;
        ifc.core_size_i      = 2'd0;
        ifc.core_signed_i    = 1'b0;
        ifc.core_addr_i      = '0;
        ifc.core_wdata_i     = '0;
        ifc.core_resp_yumi_i = 1'b1;
        test_reset();
        test_word_load();
        test_signed_byte();
        test_half_store();
        test_backpressure();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
